// File: rtl/hc04_emulator_if.sv
// Write channel and sensor lines shared by the sonar side (master) and the HC-SR04 emulator (slave).
interface hc04_emulator_if #(
  parameter int CHANNELS = 6
);
  logic [CHANNELS-1:0] hc04_trigger;
  logic [CHANNELS-1:0] hc04_echo;
  logic [3:0]          in_ctrl;
  logic [23:0]         in_data;
  logic                in_wr;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] err;

  modport master (
    output hc04_trigger, in_ctrl, in_data, in_wr,
    input  hc04_echo, busy, err
  );

  modport slave (
    input  hc04_trigger, in_ctrl, in_data, in_wr,
    output hc04_echo, busy, err
  );
endinterface

// File: rtl/hc04_emulator.sv
// Multi-channel HC-SR04 responder: echo rises LATENCY cycles after a valid trigger fall, width code*SCALE (NOECHO if 0); writes never stall.
// Define HC04_EMU_SYNC_EN to pass triggers through a two-flop synchronizer (+2 cycles on all trigger-relative timing).
module hc04_emulator #(
  parameter int CHANNELS = 6,
  parameter int TRIG_MIN = 500,
  parameter int LATENCY  = 10000,
  parameter int SCALE    = 32,
  parameter int NOECHO   = 1900000,
  parameter int HOLDOFF  = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  hc04_emulator_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRIG  = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_ECHO  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam longint CNT_MAX = 64'sd4194303;

  if (CHANNELS < 1 || CHANNELS > 8 || TRIG_MIN < 1 || LATENCY < 1 || SCALE < 1 ||
      NOECHO < 1 || HOLDOFF < 1 ||
      longint'(SCALE) * longint'(4095) > CNT_MAX || longint'(NOECHO) > CNT_MAX ||
      longint'(LATENCY) > CNT_MAX || longint'(HOLDOFF) > CNT_MAX ||
      longint'(TRIG_MIN) > CNT_MAX) begin : g_bad_params
    $error("hc04_emulator: parameters out of range for the 22-bit counter");
  end

  localparam logic [21:0] TRIG_SAT = 22'(TRIG_MIN);
  localparam logic [21:0] LAT_LD   = 22'(LATENCY - 1);
  localparam logic [21:0] HOLD_LD  = 22'(HOLDOFF - 1);
  localparam logic [21:0] NOE_LD   = 22'(NOECHO - 1);
  localparam logic [21:0] SCALE_W  = 22'(SCALE);

  logic [CHANNELS-1:0] trig_s;
  logic [CHANNELS-1:0] trig_rise;
  logic [CHANNELS-1:0] trig_prev_q, trig_prev_d;
  logic [CHANNELS-1:0] echo_q, echo_d;
  logic [CHANNELS-1:0] err_q, err_d;
  logic [CHANNELS-1:0] short_set;
  logic [CHANNELS-1:0] clr_mask;
  logic [CHANNELS-1:0] busy_c;
  logic [2:0]          state_q [CHANNELS];
  logic [2:0]          state_d [CHANNELS];
  logic [21:0]         cnt_q   [CHANNELS];
  logic [21:0]         cnt_d   [CHANNELS];
  logic [11:0]         act_q   [CHANNELS];
  logic [11:0]         act_d   [CHANNELS];
  logic [11:0]         code_q  [CHANNELS];
  logic [11:0]         code_d  [CHANNELS];
  logic                data_unused;

  assign data_unused = ^bus.in_data[23:12];

`ifdef HC04_EMU_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.hc04_trigger;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign trig_s = sync2_q;
`else
  assign trig_s = bus.hc04_trigger;
`endif

  assign trig_rise = trig_s & ~trig_prev_q;

  always_comb begin
    trig_prev_d = trig_s;
    clr_mask    = (bus.in_wr && bus.in_ctrl == 4'hE) ? bus.in_data[CHANNELS-1:0] : '0;
    echo_d      = echo_q;
    short_set   = '0;
    busy_c      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      act_d[i]   = act_q[i];
      code_d[i]  = code_q[i];
      busy_c[i]  = (state_q[i] != ST_IDLE);
      if (bus.in_wr && (bus.in_ctrl == 4'hF || bus.in_ctrl == 4'(i))) begin
        code_d[i] = bus.in_data[11:0];
      end

      case (state_q[i])
        ST_IDLE: begin
          // The sample that reveals the rise is the first high cycle of the pulse.
          if (trig_rise[i]) begin
            state_d[i] = ST_TRIG;
            cnt_d[i]   = 22'd1;
          end
        end
        ST_TRIG: begin
          if (trig_s[i]) begin
            if (cnt_q[i] < TRIG_SAT) cnt_d[i] = cnt_q[i] + 22'd1;
          end else if (cnt_q[i] >= TRIG_SAT) begin
            act_d[i]   = code_q[i];
            cnt_d[i]   = LAT_LD;
            state_d[i] = ST_BURST;
          end else begin
            short_set[i] = 1'b1;
            state_d[i]   = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (cnt_q[i] == '0) begin
            echo_d[i]  = 1'b1;
            state_d[i] = ST_ECHO;
            cnt_d[i]   = (act_q[i] == '0) ? NOE_LD : (22'(act_q[i]) * SCALE_W) - 22'd1;
          end else begin
            cnt_d[i] = cnt_q[i] - 22'd1;
          end
        end
        ST_ECHO: begin
          if (cnt_q[i] == '0) begin
            echo_d[i]  = 1'b0;
            state_d[i] = ST_HOLD;
            cnt_d[i]   = HOLD_LD;
          end else begin
            cnt_d[i] = cnt_q[i] - 22'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q[i] == '0) state_d[i] = ST_IDLE;
          else                cnt_d[i]   = cnt_q[i] - 22'd1;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
    // A short-trigger error raised in the same cycle as a clear must survive.
    err_d = (err_q & ~clr_mask) | short_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_prev_q <= '0;
      echo_q      <= '0;
      err_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        act_q[i]   <= '0;
        code_q[i]  <= '0;
      end
    end else begin
      trig_prev_q <= trig_prev_d;
      echo_q      <= echo_d;
      err_q       <= err_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      code_q      <= code_d;
    end
  end

  assign bus.hc04_echo = echo_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_hc04_emulator.sv
// Directed bench for hc04_emulator with shortened LATENCY/HOLDOFF/NOECHO so every scenario fits a short run.
module tb_hc04_emulator;
  localparam int CH    = 6;
  localparam int TMIN  = 500;
  localparam int LAT   = 100;
  localparam int SC    = 32;
  localparam int NOE   = 5000;
  localparam int HOLD  = 200;
  localparam int LIMIT = 20000;
`ifdef HC04_EMU_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clk;
  logic       rst_n;
  int         total = 0;
  int         bad   = 0;
  int         n;
  int         ext;
  logic [5:0] seen;

  hc04_emulator_if #(.CHANNELS(CH)) bus ();

  hc04_emulator #(
    .CHANNELS(CH), .TRIG_MIN(TMIN), .LATENCY(LAT),
    .SCALE(SC), .NOECHO(NOE), .HOLDOFF(HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] c, input logic [23:0] d);
    bus.in_ctrl = c;
    bus.in_data = d;
    bus.in_wr   = 1'b1;
    tick();
    bus.in_wr   = 1'b0;
  endtask

  // Trigger high for hi cycles, then one tick so the fall is sampled.
  task automatic pulse(input logic [5:0] mask, input int hi);
    bus.hc04_trigger = mask;
    repeat (hi) tick();
    bus.hc04_trigger = '0;
    tick();
  endtask

  // Ticks until echo[ch] (or busy[ch]) reaches lvl, bounded by LIMIT.
  task automatic wait_for(input bit use_busy, input int ch, input logic lvl, output int cnt);
    logic cur;
    cnt = 0;
    do begin
      tick();
      cnt++;
      cur = use_busy ? bus.busy[ch] : bus.hc04_echo[ch];
    end while (cur !== lvl && cnt < LIMIT);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.hc04_trigger = '0;
    bus.in_ctrl      = '0;
    bus.in_data      = '0;
    bus.in_wr        = 1'b0;
    tick();
    tick();
    chk("reset_echo", bus.hc04_echo, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    rst_n = 1'b1;
    tick();

    // Channel 0, code 100, 1023-cycle trigger.
    wr(4'd0, 24'd100);
    bus.hc04_trigger = 6'b000001;
    repeat (1 + SYNC) tick();
    chk("busy0_rise", bus.busy, 6'b000001);
    repeat (1022 - SYNC) tick();
    bus.hc04_trigger = '0;
    tick();
    wait_for(1'b0, 0, 1'b1, n); chk("ch0_latency", n, LAT + SYNC);
    wait_for(1'b0, 0, 1'b0, n); chk("ch0_width", n, 3200);
    wait_for(1'b1, 0, 1'b0, n); chk("ch0_holdoff", n, HOLD);

    // Channel 2, trigger one cycle short of the minimum.
    pulse(6'b000100, TMIN - 1);
    repeat (SYNC) tick();
    chk("err2_set", bus.err, 6'b000100);
    chk("busy2_idle", bus.busy, 0);
    seen = '0;
    repeat (LAT + 50) begin
      tick();
      seen |= bus.hc04_echo;
    end
    chk("ch2_no_echo", seen, 0);
    wr(4'hE, 24'h000004);
    chk("err2_cleared", bus.err, 0);

    // Channel 3: clear write lands on the same edge as a new short-trigger error.
    bus.hc04_trigger = 6'b001000;
    repeat (10) tick();
    bus.hc04_trigger = '0;
    repeat (SYNC) tick();
    bus.in_ctrl = 4'hE;
    bus.in_data = 24'h000008;
    bus.in_wr   = 1'b1;
    tick();
    bus.in_wr   = 1'b0;
    chk("err3_set_wins", bus.err, 6'b001000);
    wr(4'hE, 24'h000008);
    chk("err3_cleared", bus.err, 0);

    // Channel 5, code 0 -> NOECHO width.
    wr(4'd5, 24'd0);
    pulse(6'b100000, 600);
    wait_for(1'b0, 5, 1'b1, n); chk("ch5_latency", n, LAT + SYNC);
    wait_for(1'b0, 5, 1'b0, n); chk("ch5_noecho_width", n, NOE);
    wait_for(1'b1, 5, 1'b0, n); chk("ch5_holdoff", n, HOLD);

    // Channel 1: code rewrite and retrigger during ECHO.
    wr(4'd1, 24'd50);
    pulse(6'b000010, 600);
    wait_for(1'b0, 1, 1'b1, n); chk("ch1_latency", n, LAT + SYNC);
    ext = 0;
    wr(4'd1, 24'd10);
    ext += 1;
    pulse(6'b000010, 600);
    ext += 601;
    chk("ch1_echo_held", bus.hc04_echo, 6'b000010);
    wait_for(1'b0, 1, 1'b0, n); chk("ch1_width_unchanged", ext + n, 1600);
    chk("ch1_retrigger_no_err", bus.err, 0);
    wait_for(1'b1, 1, 1'b0, n); chk("ch1_holdoff", n, HOLD);
    pulse(6'b000010, 600);
    wait_for(1'b0, 1, 1'b1, n);
    wait_for(1'b0, 1, 1'b0, n); chk("ch1_new_code_width", n, 320);
    wait_for(1'b1, 1, 1'b0, n);

    // Broadcast code 7, all channels together.
    wr(4'hF, 24'd7);
    pulse(6'h3F, 600);
    wait_for(1'b0, 0, 1'b1, n); chk("all_latency", n, LAT + SYNC);
    chk("all_rise_aligned", bus.hc04_echo, 6'h3F);
    wait_for(1'b0, 0, 1'b0, n); chk("all_width", n, 224);
    chk("all_fall_aligned", bus.hc04_echo, 0);
    wait_for(1'b1, 0, 1'b0, n);
    chk("all_idle", bus.busy, 0);

    // Reset in the middle of an echo.
    wr(4'd3, 24'd40);
    pulse(6'b010000, 10);
    repeat (SYNC) tick();
    chk("err4_set", bus.err, 6'b010000);
    pulse(6'b001000, 600);
    wait_for(1'b0, 3, 1'b1, n); chk("ch3_latency", n, LAT + SYNC);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midecho_reset_echo", bus.hc04_echo, 0);
    chk("midecho_reset_busy", bus.busy, 0);
    chk("midecho_reset_err", bus.err, 0);
    rst_n = 1'b1;
    tick();
    pulse(6'b001000, 600);
    wait_for(1'b0, 3, 1'b1, n);
    wait_for(1'b0, 3, 1'b0, n); chk("ch3_post_reset_noecho", n, NOE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
